ciaa_kbd_serial: RTL and testbench

Buffers Amiga raw key codes from the PS/2 keyboard translator and transmits them to CIA-A's serial port. It uses the native Amiga keyboard line protocol: KDAT/KCLK bit framing, host handshake, and lost-sync recovery. It sits between the translator's `keydat`/`keystrobe`/`keyack` handshake and the CIA-A `SP`/`CNT` inputs. All sequential logic advances only on `clk7_en` ticks.

---
 rtl/ciaa_kbd_serial.sv | 234 +++++++++++++++++++++++
 tb/tb_ciaa_kbd_serial.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ciaa_kbd_serial.sv
`default_nettype none
// ============================================================================
// Module   : ciaa_kbd_serial
// Brief    : Amiga keyboard link: raw-code FIFO, KDAT/KCLK framing, host
//            handshake and lost-sync recovery toward the CIA-A serial port.
// Revision : 1.0
// ============================================================================
module ciaa_kbd_serial #(
    parameter int DEPTH      = 8,
    parameter int T_BIT      = 142,
    parameter int HS_MIN     = 500,
    parameter int HS_TIMEOUT = 1014000,
    parameter int SEND_INIT  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk7_en,
    input  logic [7:0]               keydat,
    input  logic                     keystrobe,
    output logic                     keyack,
    input  logic                     cia_sp_i,
    output logic                     kbd_sp_o,
    output logic                     kbd_cnt_o,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [19:0]   C_TBIT_LAST = 20'(T_BIT - 1);
    localparam logic [19:0]   C_HSMIN_LAST = 20'(HS_MIN - 1);
    localparam logic [19:0]   C_TO_LAST = 20'(HS_TIMEOUT - 1);
    localparam logic [LW-1:0] C_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] C_INIT_LVL = LW'((SEND_INIT != 0) ? 2 : 0);
    localparam logic [AW-1:0] C_INIT_WPTR = AW'((SEND_INIT != 0) ? 2 : 0);
    localparam logic [7:0]    C_LOST_SYNC = 8'hF9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CLKLO  = 3'd2,
        S_CLKHI  = 3'd3,
        S_HSWAIT = 3'd4,
        S_HSREL  = 3'd5,
        S_RESYNC = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        M_NORMAL   = 2'd0,
        M_RESYNC   = 2'd1,
        M_LOSTSYNC = 2'd2
    } mode_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_keyack, r_overflow;
    logic          r_sp_s1, r_sp_s2;

    state_t        r_state, w_state_nx;
    mode_t         r_mode, w_mode_nx;
    logic [19:0]   r_timer, w_timer_nx;
    logic [19:0]   r_low, w_low_nx;
    logic [3:0]    r_bits, w_bits_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic [7:0]    r_code, w_code_nx;

    logic          w_full, w_empty, w_try, w_wr, w_pop;
    logic [7:0]    w_rd_data;

    function automatic logic [7:0] f_rot(input logic [7:0] c);
        return {c[6:0], c[7]};
    endfunction

    assign w_full    = (r_level == C_FULL);
    assign w_empty   = (r_level == '0);
    assign w_try     = clk7_en & keystrobe & ~r_keyack;
    assign w_wr      = w_try & ~w_full;
    assign w_pop     = clk7_en & (r_state == S_IDLE) & ~w_empty;
    assign w_rd_data = r_mem[r_rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            if (SEND_INIT != 0) begin
                r_mem[0] <= 8'hFD;
                r_mem[1] <= 8'hFE;
            end
            r_wptr     <= C_INIT_WPTR;
            r_rptr     <= '0;
            r_level    <= C_INIT_LVL;
            r_keyack   <= 1'b0;
            r_overflow <= 1'b0;
            r_sp_s1    <= 1'b1;
            r_sp_s2    <= 1'b1;
        end else if (clk7_en) begin
            if (w_wr) begin
                r_mem[r_wptr] <= keydat;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_keyack <= w_wr;
            if (w_try && w_full) r_overflow <= 1'b1;
            r_sp_s1 <= cia_sp_i;
            r_sp_s2 <= r_sp_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= M_NORMAL;
            r_timer <= '0;
            r_low   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_code  <= '0;
        end else if (clk7_en) begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_timer <= w_timer_nx;
            r_low   <= w_low_nx;
            r_bits  <= w_bits_nx;
            r_shift <= w_shift_nx;
            r_code  <= w_code_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_bits_nx  = r_bits;
        w_shift_nx = r_shift;
        w_code_nx  = r_code;
        w_low_nx   = '0;
        w_timer_nx = (r_timer == '1) ? r_timer : r_timer + 20'd1;
        case (r_state)
            S_IDLE: begin
                w_timer_nx = '0;
                if (!w_empty) begin
                    w_code_nx  = w_rd_data;
                    w_shift_nx = f_rot(w_rd_data);
                    w_bits_nx  = 4'd8;
                    w_mode_nx  = M_NORMAL;
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP, S_RESYNC: begin
                if (r_timer == C_TBIT_LAST) begin
                    w_timer_nx = '0;
                    w_state_nx = S_CLKLO;
                end
            end
            S_CLKLO: begin
                if (r_timer == C_TBIT_LAST) begin
                    w_timer_nx = '0;
                    w_state_nx = S_CLKHI;
                end
            end
            S_CLKHI: begin
                if (r_timer == C_TBIT_LAST) begin
                    w_timer_nx = '0;
                    if (r_bits == 4'd1) begin
                        w_bits_nx  = 4'd0;
                        w_state_nx = S_HSWAIT;
                    end else begin
                        w_bits_nx  = r_bits - 4'd1;
                        w_shift_nx = {r_shift[6:0], 1'b0};
                        w_state_nx = S_SETUP;
                    end
                end
            end
            S_HSWAIT: begin
                if (!r_sp_s2) w_low_nx = (r_low == '1) ? r_low : r_low + 20'd1;
                if (!r_sp_s2 && r_low == C_HSMIN_LAST) begin
                    w_timer_nx = '0;
                    w_low_nx   = '0;
                    w_state_nx = S_HSREL;
                end else if (r_timer == C_TO_LAST) begin
                    // Resync clocks out a lone '1' (SP low); r_code is kept for retransmission
                    w_timer_nx = '0;
                    w_low_nx   = '0;
                    w_mode_nx  = M_RESYNC;
                    w_shift_nx = 8'h80;
                    w_bits_nx  = 4'd1;
                    w_state_nx = S_RESYNC;
                end
            end
            S_HSREL: begin
                if (r_sp_s2) begin
                    w_timer_nx = '0;
                    case (r_mode)
                        M_RESYNC: begin
                            w_shift_nx = f_rot(C_LOST_SYNC);
                            w_bits_nx  = 4'd8;
                            w_mode_nx  = M_LOSTSYNC;
                            w_state_nx = S_SETUP;
                        end
                        M_LOSTSYNC: begin
                            w_shift_nx = f_rot(r_code);
                            w_bits_nx  = 4'd8;
                            w_mode_nx  = M_NORMAL;
                            w_state_nx = S_SETUP;
                        end
                        default: w_state_nx = S_IDLE;
                    endcase
                end
            end
            default: begin
                w_timer_nx = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (r_state)
            S_SETUP, S_CLKLO, S_CLKHI: kbd_sp_o = ~r_shift[7];
            S_RESYNC:                  kbd_sp_o = 1'b0;
            default:                   kbd_sp_o = 1'b1;
        endcase
    end

    assign kbd_cnt_o  = (r_state != S_CLKLO);
    assign keyack     = r_keyack;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_ciaa_kbd_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_ciaa_kbd_serial
// Brief    : Directed self-checking bench for ciaa_kbd_serial (scaled timing).
// Revision : 1.0
// ============================================================================
module tb_ciaa_kbd_serial;
    localparam int DEPTH      = 8;
    localparam int T_BIT      = 4;
    localparam int HS_MIN     = 10;
    localparam int HS_TIMEOUT = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk7_en = 1'b0;
    logic [7:0] keydat = 8'h00;
    logic       keystrobe = 1'b0;
    logic       cia_sp_i = 1'b1;
    logic       keyack, kbd_sp_o, kbd_cnt_o, overflow;
    logic [3:0] fifo_level;

    int checks = 0;
    int failures = 0;
    int tick_n = 0;
    int wr_tick = 0;
    int rt [8];
    bit rx_b [$];
    int rx_t [$];
    logic prev_cnt = 1'b1;

    ciaa_kbd_serial #(
        .DEPTH(DEPTH), .T_BIT(T_BIT), .HS_MIN(HS_MIN),
        .HS_TIMEOUT(HS_TIMEOUT), .SEND_INIT(1)
    ) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .keydat(keydat),
        .keystrobe(keystrobe), .keyack(keyack), .cia_sp_i(cia_sp_i),
        .kbd_sp_o(kbd_sp_o), .kbd_cnt_o(kbd_cnt_o),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(negedge clk) clk7_en = ~clk7_en;
    always @(posedge clk) if (clk7_en) tick_n = tick_n + 1;

    // Host-side receiver: capture the data bit on every KCLK rising edge
    always @(negedge clk) begin
        if (!reset && prev_cnt === 1'b0 && kbd_cnt_o === 1'b1) begin
            rx_b.push_back(~kbd_sp_o);
            rx_t.push_back(tick_n);
        end
        prev_cnt = kbd_cnt_o;
    end

    task automatic tick();
        @(posedge clk);
        while (clk7_en !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic collect(input int budget, output logic [7:0] v, output bit ok);
        int b = 0;
        bit bb;
        while (rx_b.size() < 8 && b < budget) begin
            tick();
            b++;
        end
        ok = (rx_b.size() >= 8);
        v = 8'h00;
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                bb = rx_b.pop_front();
                v = {v[6:0], bb};
                rt[i] = rx_t.pop_front();
            end
        end else begin
            rx_b.delete();
            rx_t.delete();
        end
    endtask

    task automatic host_hs(input int len);
        ticks(T_BIT + 2);
        cia_sp_i = 1'b0;
        ticks(len);
        cia_sp_i = 1'b1;
    endtask

    task automatic send_code(input logic [7:0] d, input int max_t, output bit acked, output int lat);
        keydat = d;
        keystrobe = 1'b1;
        acked = 1'b0;
        lat = 0;
        while (!acked && lat < max_t) begin
            tick();
            lat++;
            if (keyack === 1'b1) acked = 1'b1;
        end
        if (acked) begin
            keystrobe = 1'b0;
            wr_tick = tick_n;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (kbd_sp_o !== 1'b1) begin failures++; $display("FAIL reset_sp: got %b required 1", kbd_sp_o); end
        checks++; if (kbd_cnt_o !== 1'b1) begin failures++; $display("FAIL reset_cnt: got %b required 1", kbd_cnt_o); end
        checks++; if (keyack !== 1'b0) begin failures++; $display("FAIL reset_keyack: got %b required 0", keyack); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        checks++; if (fifo_level !== 4'd2) begin failures++; $display("FAIL reset_level: got %0d required 2", fifo_level); end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (fifo_level !== 4'd2) begin failures++; $display("FAIL post_reset_level: got %0d required 2", fifo_level); end
    endtask

    task automatic test_init();
        logic [7:0] v;
        bit ok;
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'hFB) begin failures++; $display("FAIL init_fd: got %h ok=%0d required fb", v, ok); end
        host_hs(15);
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'hFD) begin failures++; $display("FAIL init_fe: got %h ok=%0d required fd", v, ok); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL init_level: got %0d required 0", fifo_level); end
        host_hs(15);
        ticks(10);
    endtask

    task automatic test_encode();
        logic [7:0] v;
        bit ok, acked;
        int lat, wt;
        send_code(8'h45, 6, acked, lat);
        wt = wr_tick;
        checks++; if (!acked || lat != 1) begin failures++; $display("FAIL enc_ack_latency: got acked=%0d lat=%0d required 1", acked, lat); end
        tick();
        checks++; if (keyack !== 1'b0) begin failures++; $display("FAIL enc_ack_width: got %b required 0", keyack); end
        send_code(8'hA3, 6, acked, lat);
        checks++; if (!acked) begin failures++; $display("FAIL enc_second_ack: got 0 required 1"); end
        checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL enc_level: got %0d required 1", fifo_level); end
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'h8A) begin failures++; $display("FAIL enc_bits: got %h ok=%0d required 8a", v, ok); end
        checks++; if (rt[0] != wt + 1 + 2 * T_BIT) begin failures++; $display("FAIL enc_first_rise: got %0d required %0d", rt[0], wt + 1 + 2 * T_BIT); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rt[i+1] - rt[i] != 3 * T_BIT) begin failures++; $display("FAIL enc_spacing[%0d]: got %0d required %0d", i, rt[i+1] - rt[i], 3 * T_BIT); end
        end
    endtask

    task automatic test_handshake();
        logic [7:0] v;
        bit ok;
        int rel;
        ticks(T_BIT + 2);
        cia_sp_i = 1'b0;
        ticks(4);
        cia_sp_i = 1'b1;
        ticks(30);
        checks++; if (rx_b.size() != 0) begin failures++; $display("FAIL hs_short_bits: got %0d required 0", rx_b.size()); end
        checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL hs_short_level: got %0d required 1", fifo_level); end
        cia_sp_i = 1'b0;
        ticks(15);
        cia_sp_i = 1'b1;
        rel = tick_n;
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'h47) begin failures++; $display("FAIL hs_next_bits: got %h ok=%0d required 47", v, ok); end
        checks++; if (rt[0] != rel + 4 + 2 * T_BIT) begin failures++; $display("FAIL hs_next_start: got %0d required %0d", rt[0], rel + 4 + 2 * T_BIT); end
        host_hs(15);
        ticks(10);
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        bit ok, acked, bb;
        int lat, last, b, bt;
        send_code(8'h12, 6, acked, lat);
        collect(200, v, ok);
        last = rt[7];
        checks++; if (!ok || v !== 8'h24) begin failures++; $display("FAIL to_first_bits: got %h ok=%0d required 24", v, ok); end
        b = 0;
        while (rx_b.size() == 0 && b < HS_TIMEOUT + 100) begin tick(); b++; end
        checks++;
        if (rx_b.size() == 0) begin
            failures++; $display("FAIL to_resync_bit: got none required 1");
        end else begin
            bb = rx_b.pop_front();
            bt = rx_t.pop_front();
            if (bb !== 1'b1) begin failures++; $display("FAIL to_resync_bit: got %b required 1", bb); end
            checks++;
            if (bt != last + 3 * T_BIT + HS_TIMEOUT) begin failures++; $display("FAIL to_resync_time: got %0d required %0d", bt, last + 3 * T_BIT + HS_TIMEOUT); end
        end
        ticks(T_BIT + 2);
        checks++; if (rx_b.size() != 0) begin failures++; $display("FAIL to_single_bit: got %0d extra required 0", rx_b.size()); end
        checks++; if (kbd_sp_o !== 1'b1) begin failures++; $display("FAIL to_sp_release: got %b required 1", kbd_sp_o); end
        host_hs(15);
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'hF3) begin failures++; $display("FAIL to_lost_sync: got %h ok=%0d required f3", v, ok); end
        host_hs(15);
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'h24) begin failures++; $display("FAIL to_retransmit: got %h ok=%0d required 24", v, ok); end
        host_hs(15);
        ticks(10);
    endtask

    task automatic test_full();
        logic [7:0] v;
        bit ok, acked;
        int lat, b;
        send_code(8'h01, 6, acked, lat);
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'h02) begin failures++; $display("FAIL full_first: got %h ok=%0d required 02", v, ok); end
        for (int i = 0; i < DEPTH; i++) begin
            send_code(8'h10 + 8'(i), 6, acked, lat);
            checks++; if (!acked) begin failures++; $display("FAIL full_ack[%0d]: got 0 required 1", i); end
            checks++; if (fifo_level !== 4'(i + 1)) begin failures++; $display("FAIL full_level[%0d]: got %0d required %0d", i, fifo_level, i + 1); end
        end
        send_code(8'h20, 6, acked, lat);
        checks++; if (acked) begin failures++; $display("FAIL full_nack: got ack required none"); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_overflow: got %b required 1", overflow); end
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_level_max: got %0d required 8", fifo_level); end
        host_hs(15);
        b = 0;
        acked = 1'b0;
        while (!acked && b < 10) begin
            tick();
            b++;
            if (keyack === 1'b1) acked = 1'b1;
        end
        keystrobe = 1'b0;
        checks++; if (!acked) begin failures++; $display("FAIL full_late_ack: got none required ack"); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        bit ok;
        int b = 0;
        while (kbd_cnt_o !== 1'b0 && b < 100) begin tick(); b++; end
        checks++; if (kbd_cnt_o !== 1'b0) begin failures++; $display("FAIL mid_clklo_reached: got %b required 0", kbd_cnt_o); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (kbd_sp_o !== 1'b1) begin failures++; $display("FAIL mid_sp: got %b required 1", kbd_sp_o); end
        checks++; if (kbd_cnt_o !== 1'b1) begin failures++; $display("FAIL mid_cnt: got %b required 1", kbd_cnt_o); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow: got %b required 0", overflow); end
        checks++; if (fifo_level !== 4'd2) begin failures++; $display("FAIL mid_level: got %0d required 2", fifo_level); end
        repeat (4) @(negedge clk);
        rx_b.delete();
        rx_t.delete();
        reset = 1'b0;
        collect(200, v, ok);
        checks++; if (!ok || v !== 8'hFB) begin failures++; $display("FAIL mid_reinit: got %h ok=%0d required fb", v, ok); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_encode();
        test_handshake();
        test_timeout();
        test_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
